// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally, buffers {pc, instr} for decode.
// Redirects flush the buffer; misaligned or out-of-range PCs raise a sticky fault that halts fetch.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    INSTR_MEM_SIZE = 4096,
  parameter int                    FIFO_DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  fetch_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(INSTR_MEM_SIZE - 4);
  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic                  fault_q, fault_d;

  logic [ADDR_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];

  logic pc_bad, redirect_bad, pop, push;

  // Any PC above LAST_PC also covers pc+4 wrapping past the top of the address space.
  assign pc_bad       = (pc_q[1:0] != 2'b00) | (pc_q > LAST_PC);
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) | (redirect_pc > LAST_PC);

  assign pop  = out_valid & out_ready;
  assign push = ~fault_q & ~pc_bad & ~redirect_valid & ((count_q < DEPTH_C) | pop);

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fault_d  = fault_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fault_d  = redirect_bad;
    end else begin
      if (pc_bad) fault_d = 1'b1;
      if (push) begin
        pc_d     = pc_q + ADDR_WIDTH'(4);
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fault_q  <= fault_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = (count_q != '0);
  assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign fetch_fault = fault_q;

endmodule
